fir_controller: RTL and testbench

FIR_CONTROLLER -- requirements
Module: fir_controller

---
 rtl/fir_pkg.sv | 33 +++
 rtl/tap_counter.sv | 39 +++
 rtl/fir_controller.sv | 117 +++++++++++
 tb/tb_fir_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR sequencing controller:
//   - state_t / ST_* : 3-bit FSM state encoding
//   - DRAIN_W        : width of the MAC-latency drain counter
//   - addr_width()   : ceil(log2(n)), used to size the tap address
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SHIFT = 3'd1;
    localparam state_t ST_MAC   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // MAC latency is at most 7, so a 3-bit counter always suffices.
    localparam int DRAIN_W = 3;

    // Smallest w with 2**w >= n; n is limited to 2..1024.
    function automatic int addr_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tap_counter.sv
// -----------------------------------------------------------------------------
// tap_counter
// WIDTH-bit up-counter with enable, synchronous clear (priority over enable),
// asynchronous active-high reset and a terminal-count flag.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-high, forces count to 0
//   en    : increment this cycle
//   clr   : synchronous clear to 0
//   count : current count
//   tc    : high while count == TERMINAL
// -----------------------------------------------------------------------------
module tap_counter #(
    parameter int WIDTH    = 6,
    parameter int TERMINAL = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/fir_controller.sv
// -----------------------------------------------------------------------------
// fir_controller
// Sequencer for a single-MAC FIR filter. For every accepted input sample it
// strobes the delay-line shift and accumulator clear once, walks the tap
// pointer 0..LENGTH-1 with mac_en, waits MAC_LAT cycles for the MAC pipeline
// to empty, then presents out_valid until downstream takes it.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : input sample handshake (ready only in IDLE)
//   shift_enb            : delay-line shift strobe
//   pointer              : tap index for register file and coefficient ROM
//   mac_clr / mac_en     : accumulator clear / accumulate strobes
//   mac_last             : final tap marker (with mac_en)
//   out_valid / out_ready: output sample handshake
//   busy                 : controller not in IDLE
// All outputs are decoded from registered state or counter registers.
// -----------------------------------------------------------------------------
module fir_controller
    import fir_pkg::*;
#(
    parameter  int LENGTH  = 64,
    parameter  int MAC_LAT = 2,
    localparam int ADDR_W  = addr_width(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_enb,
    output logic [ADDR_W-1:0] pointer,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // With MAC_LAT = 0 the drain counter is never enabled; its terminal value
    // is irrelevant but must still be a legal constant.
    localparam int DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    state_t               state;
    state_t               state_nxt;
    logic                 ptr_tc;
    logic                 in_mac;
    logic                 in_drain;
    logic                 drain_tc;
    logic [DRAIN_W-1:0]   drain_cnt;

    assign in_mac   = (state == ST_MAC);
    assign in_drain = (state == ST_DRAIN);

    // Tap pointer: counts only in MAC and clears itself on the last tap, so it
    // rests at 0 everywhere else and never wraps.
    tap_counter #(
        .WIDTH    (ADDR_W),
        .TERMINAL (LENGTH - 1)
    ) u_tap_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (in_mac),
        .clr   (in_mac & ptr_tc),
        .count (pointer),
        .tc    (ptr_tc)
    );

    // Drain counter: one count per DRAIN cycle, self-clearing on exit.
    tap_counter #(
        .WIDTH    (DRAIN_W),
        .TERMINAL (DRAIN_LAST)
    ) u_drain_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (in_drain),
        .clr   (in_drain & drain_tc),
        .count (drain_cnt),
        .tc    (drain_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = ST_MAC;
            ST_MAC:   if (ptr_tc) state_nxt = (MAC_LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (drain_tc) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are pure state decodes; mutual exclusion follows from the
    // states being exclusive, and mac_last is qualified by MAC.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign shift_enb = (state == ST_SHIFT);
    assign mac_clr   = (state == ST_SHIFT);
    assign mac_en    = in_mac;
    assign mac_last  = in_mac & ptr_tc;
    assign out_valid = (state == ST_DONE);

    // Counters must stay inside their ranges while their state is active.
    a_drain_range : assert property (@(posedge clk) disable iff (rst)
        !in_drain || (int'(drain_cnt) < MAC_LAT));
    a_ptr_range : assert property (@(posedge clk) disable iff (rst)
        int'(pointer) < LENGTH);

endmodule

// File: tb/tb_fir_controller.sv
// -----------------------------------------------------------------------------
// tb_fir_controller
// Three controller instances: A (LENGTH=4, MAC_LAT=2), B (LENGTH=2,
// MAC_LAT=0) and C (LENGTH=64, MAC_LAT=2). A phase-counting reference model
// predicts every output each cycle; accepted samples push their expected
// out_valid cycle into a per-instance queue that is popped at the output
// handshake, together with per-sample shift/MAC strobe counts.
// -----------------------------------------------------------------------------
module tb_fir_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_iv = 1'b0, a_ordy = 1'b1;
    logic       a_in_ready, a_shift_enb, a_mac_clr, a_mac_en, a_mac_last, a_out_valid, a_busy;
    logic [1:0] a_pointer;

    logic       b_iv = 1'b0, b_ordy = 1'b1;
    logic       b_in_ready, b_shift_enb, b_mac_clr, b_mac_en, b_mac_last, b_out_valid, b_busy;
    logic [0:0] b_pointer;

    logic       c_iv = 1'b0, c_ordy = 1'b1;
    logic       c_in_ready, c_shift_enb, c_mac_clr, c_mac_en, c_mac_last, c_out_valid, c_busy;
    logic [5:0] c_pointer;

    fir_controller #(.LENGTH(4), .MAC_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_in_ready),
        .shift_enb(a_shift_enb), .pointer(a_pointer), .mac_clr(a_mac_clr),
        .mac_en(a_mac_en), .mac_last(a_mac_last), .out_valid(a_out_valid),
        .out_ready(a_ordy), .busy(a_busy)
    );

    fir_controller #(.LENGTH(2), .MAC_LAT(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_in_ready),
        .shift_enb(b_shift_enb), .pointer(b_pointer), .mac_clr(b_mac_clr),
        .mac_en(b_mac_en), .mac_last(b_mac_last), .out_valid(b_out_valid),
        .out_ready(b_ordy), .busy(b_busy)
    );

    fir_controller #(.LENGTH(64), .MAC_LAT(2)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_in_ready),
        .shift_enb(c_shift_enb), .pointer(c_pointer), .mac_clr(c_mac_clr),
        .mac_en(c_mac_en), .mac_last(c_mac_last), .out_valid(c_out_valid),
        .out_ready(c_ordy), .busy(c_busy)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    phase [3] = '{-1, -1, -1};
    int    exp_q [3][$];
    int    acc_hist [3][$];
    int    ov_first [3] = '{0, 0, 0};
    bit    ov_prev [3] = '{1'b0, 1'b0, 1'b0};
    int    n_shift [3] = '{0, 0, 0};
    int    n_mac [3] = '{0, 0, 0};
    int    n_done [3] = '{0, 0, 0};
    string names [3] = '{"A", "B", "C"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // obs packing: {in_ready, busy, shift_enb, mac_clr, mac_en, mac_last, out_valid}
    task automatic monitor(input int id, input int L, input int LAT, input logic iv,
                           input logic ordy, input logic [6:0] obs, input int ptr);
        logic [6:0] exp;
        int         eptr;
        int         ph;
        exp  = '0;
        eptr = 0;
        if (rst) begin
            phase[id] = -1;
            exp_q[id].delete();
        end
        ph = phase[id];
        if (ph < 0) begin
            exp[6] = 1'b1;
        end else begin
            exp[5] = 1'b1;
            if (ph == 0) begin
                exp[4] = 1'b1;
                exp[3] = 1'b1;
            end else if (ph <= L) begin
                exp[2] = 1'b1;
                eptr   = ph - 1;
                if (ph == L) exp[1] = 1'b1;
            end else if (ph > L + LAT) begin
                exp[0] = 1'b1;
            end
        end
        check($sformatf("%s.outs", names[id]), int'(obs), int'(exp));
        check($sformatf("%s.ptr", names[id]), ptr, eptr);

        n_shift[id] += int'(obs[4]);
        n_mac[id]   += int'(obs[2]);
        if (obs[0] && !ov_prev[id]) ov_first[id] = cyc;
        ov_prev[id] = obs[0];

        if (!rst) begin
            if (ph < 0) begin
                if (iv) begin
                    phase[id] = 0;
                    exp_q[id].push_back(cyc + 2 + L + LAT);
                    acc_hist[id].push_back(cyc + 1);
                    n_shift[id] = 0;
                    n_mac[id]   = 0;
                end
            end else if (ph > L + LAT) begin
                if (ordy) begin
                    phase[id] = -1;
                    check($sformatf("%s.sb_nonempty", names[id]), int'(exp_q[id].size() > 0), 1);
                    if (exp_q[id].size() > 0)
                        check($sformatf("%s.latency", names[id]), ov_first[id], exp_q[id].pop_front());
                    check($sformatf("%s.n_shift", names[id]), n_shift[id], 1);
                    check($sformatf("%s.n_mac", names[id]), n_mac[id], L);
                    n_done[id]++;
                end
            end else begin
                phase[id] = ph + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0, 4, 2, a_iv, a_ordy,
                {a_in_ready, a_busy, a_shift_enb, a_mac_clr, a_mac_en, a_mac_last, a_out_valid},
                int'(a_pointer));
        monitor(1, 2, 0, b_iv, b_ordy,
                {b_in_ready, b_busy, b_shift_enb, b_mac_clr, b_mac_en, b_mac_last, b_out_valid},
                int'(b_pointer));
        monitor(2, 64, 2, c_iv, c_ordy,
                {c_in_ready, c_busy, c_shift_enb, c_mac_clr, c_mac_en, c_mac_last, c_out_valid},
                int'(c_pointer));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int done_before;

        // Reset state
        tick(3);
        check("rst.in_ready", int'(a_in_ready), 1);
        check("rst.busy", int'(a_busy), 0);
        check("rst.out_valid", int'(a_out_valid), 0);
        check("rst.ptr", int'(a_pointer), 0);
        rst = 1'b0;
        tick(2);

        // Single pulse on A: timing checked cycle by cycle by the model
        a_iv = 1'b1;
        tick(1);
        a_iv = 1'b0;
        tick(12);
        check("A.first_done", n_done[0], 1);

        // Back-pressure in DONE for 5 cycles
        a_ordy = 1'b0;
        a_iv   = 1'b1;
        tick(1);
        a_iv = 1'b0;
        for (int i = 0; i < 20 && !a_out_valid; i++) tick(1);
        check("A.done_reached", int'(a_out_valid), 1);
        tick(5);
        check("A.hold_ov", int'(a_out_valid), 1);
        check("A.hold_in_ready", int'(a_in_ready), 0);
        a_ordy = 1'b1;
        tick(1);
        check("A.rel_in_ready", int'(a_in_ready), 1);
        check("A.rel_ov", int'(a_out_valid), 0);
        tick(2);

        // Continuous in_valid with out_ready high: fixed sample period
        acc_hist[0].delete();
        a_iv = 1'b1;
        tick(40);
        a_iv = 1'b0;
        tick(15);
        check("A.n_acc", int'(acc_hist[0].size() >= 4), 1);
        for (int i = 1; i < acc_hist[0].size(); i++)
            check("A.period", acc_hist[0][i] - acc_hist[0][i-1], 9);

        // Asynchronous reset while pointer = 2
        done_before = n_done[0];
        a_iv = 1'b1;
        tick(1);
        a_iv = 1'b0;
        for (int i = 0; i < 10 && int'(a_pointer) != 2; i++) tick(1);
        check("A.ptr2_reached", int'(int'(a_pointer) == 2), 1);
        #2 rst = 1'b1;
        #1;
        check("A.rst_in_ready", int'(a_in_ready), 1);
        check("A.rst_busy", int'(a_busy), 0);
        check("A.rst_mac_en", int'(a_mac_en), 0);
        check("A.rst_ptr", int'(a_pointer), 0);
        check("A.rst_ov", int'(a_out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(15);
        check("A.no_out_after_rst", n_done[0], done_before);

        // B: LENGTH=2, MAC_LAT=0, no drain cycle
        done_before = n_done[1];
        b_iv = 1'b1;
        tick(1);
        b_iv = 1'b0;
        tick(8);
        check("B.done", n_done[1], done_before + 1);

        // C: LENGTH=64 with random stalls on both handshakes
        for (int i = 0; i < 3000; i++) begin
            c_iv   = ($urandom_range(0, 2) == 0);
            c_ordy = $urandom_range(0, 1) == 1;
            tick(1);
        end
        c_iv   = 1'b0;
        c_ordy = 1'b1;
        tick(100);
        check("C.samples", int'(n_done[2] >= 5), 1);
        check("C.sb_left", exp_q[2].size(), 0);
        check("A.sb_left", exp_q[0].size(), 0);
        check("B.sb_left", exp_q[1].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
